// File: rtl/error_resp_sequencer.sv
// Error response sequencer: serves pending error requests by fixed priority through the builder and the tx handshake.
// Optional feature: define ERR_RESP_PENDING_EN to accumulate err_req in every state instead of only in IDLE.

module error_resp_sequencer #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  err_req,
    output logic        build_enable,
    output logic [5:0]  build_err,
    input  logic        build_ready,
    input  logic [31:0] build_header,
    output logic        tx_valid,
    output logic [31:0] tx_header,
    input  logic        tx_ready,
    output logic        busy,
    output logic        timeout,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        WAIT_RDY,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] BUSY_BIT     = 6'b000100;

    state_t      state_q, state_d;
    logic [5:0]  pend_q, pend_d;
    logic [5:0]  served_q, served_d;
    logic [5:0]  build_err_q, build_err_d;
    logic        build_enable_q, build_enable_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] tx_header_q, tx_header_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  drop_q, drop_d;

    logic [5:0]  req_in;
    logic        drop_evt;
    logic [5:0]  winner;

    function automatic logic [5:0] pick_highest(input logic [5:0] v);
        logic [5:0] r;
        r = 6'b0;
        for (int i = 0; i < 6; i++) begin
            if (v[i]) r = 6'b000001 << i;
        end
        return r;
    endfunction

    always_comb begin
`ifdef ERR_RESP_PENDING_EN
        req_in   = err_req;
        drop_evt = 1'b0;
`else
        req_in   = (state_q == IDLE) ? err_req : 6'b0;
        drop_evt = (state_q != IDLE) && (err_req != 6'b0);
`endif
        winner   = pick_highest(pend_q | err_req);
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q | req_in;
        served_d       = served_q;
        build_err_d    = build_err_q;
        build_enable_d = build_enable_q;
        tx_valid_d     = tx_valid_q;
        tx_header_d    = tx_header_q;
        busy_d         = busy_q;
        timeout_d      = 1'b0;
        cnt_d          = cnt_q;
        drop_d         = (drop_evt && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        case (state_q)
            IDLE: begin
                if (winner != 6'b0) begin
                    served_d       = winner;
                    build_err_d    = winner;
                    build_enable_d = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = BUILD;
                end
            end
            BUILD: begin
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (build_ready) begin
                    tx_header_d    = build_header;
                    build_enable_d = 1'b0;
                    tx_valid_d     = 1'b1;
                    cnt_d          = 8'd0;
                    state_d        = SEND;
                end
            end
            SEND: begin
                // A handshake in the cycle the limit is reached still counts as delivered.
                if (tx_ready) begin
                    tx_valid_d  = 1'b0;
                    build_err_d = 6'b0;
                    state_d     = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    tx_valid_d  = 1'b0;
                    build_err_d = 6'b0;
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // Busy retry from an abort and fresh requests are applied after the clear so they survive.
                pend_d   = (pend_q & ~served_q) | req_in | (timeout_q ? BUSY_BIT : 6'b0);
                served_d = 6'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pend_q         <= 6'b0;
            served_q       <= 6'b0;
            build_err_q    <= 6'b0;
            build_enable_q <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_header_q    <= 32'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
            cnt_q          <= 8'd0;
            drop_q         <= 8'd0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            served_q       <= served_d;
            build_err_q    <= build_err_d;
            build_enable_q <= build_enable_d;
            tx_valid_q     <= tx_valid_d;
            tx_header_q    <= tx_header_d;
            busy_q         <= busy_d;
            timeout_q      <= timeout_d;
            cnt_q          <= cnt_d;
            drop_q         <= drop_d;
        end
    end

    assign build_enable = build_enable_q;
    assign build_err    = build_err_q;
    assign tx_valid     = tx_valid_q;
    assign tx_header    = tx_header_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_error_resp_sequencer.sv
// Self-checking bench for error_resp_sequencer: vector table, corner-case sequences and random traffic vs a reference model.
// Honours ERR_RESP_PENDING_EN the same way as the design.

module tb_error_resp_sequencer;

    localparam int TMO = 4;
`ifdef ERR_RESP_PENDING_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam logic [31:0] HDR = 32'hA5C3_0102;

    logic        clk;
    logic        reset_n;
    logic [5:0]  err_req;
    logic        build_enable;
    logic [5:0]  build_err;
    logic        build_ready;
    logic [31:0] build_header;
    logic        tx_valid;
    logic [31:0] tx_header;
    logic        tx_ready;
    logic        busy;
    logic        timeout;
    logic [7:0]  drop_count;

    error_resp_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .err_req      (err_req),
        .build_enable (build_enable),
        .build_err    (build_err),
        .build_ready  (build_ready),
        .build_header (build_header),
        .tx_valid     (tx_valid),
        .tx_header    (tx_header),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .timeout      (timeout),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0..4 = idle, build, wait-ready, send, done; outputs derive from the phase.
    int          ph;
    bit          pendArr[6];
    int          servedIdx;
    int          sendCycles;
    int          dropCnt;
    bit          timedOut;
    logic [31:0] hdrQ;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0] req;
        logic       br;
        logic       tr;
        logic       expEn;
        logic [5:0] expErr;
        logic       expValid;
        logic       expBusy;
    } vec_t;

    vec_t vecs[5];

    task automatic modelReset();
        ph = 0;
        foreach (pendArr[i]) pendArr[i] = 1'b0;
        servedIdx  = -1;
        sendCycles = 0;
        dropCnt    = 0;
        timedOut   = 1'b0;
        hdrQ       = 32'b0;
    endtask

    task automatic modelStep(input logic [5:0] req, input logic br, input logic [31:0] hdr, input logic tr);
        bit acceptAll;
        int w;
        acceptAll = (PEN == 1) || (ph == 0);
        if (!acceptAll && req != 6'b0 && dropCnt < 255) dropCnt++;
        case (ph)
            0: begin
                w = -1;
                for (int i = 0; i < 6; i++) if (pendArr[i] || req[i]) w = i;
                if (w >= 0) begin
                    servedIdx = w;
                    ph = 1;
                end
            end
            1: ph = 2;
            2: if (br) begin
                hdrQ = hdr;
                sendCycles = 0;
                ph = 3;
            end
            3: begin
                sendCycles++;
                if (tr) begin
                    timedOut = 1'b0;
                    ph = 4;
                end else if (sendCycles == TMO) begin
                    timedOut = 1'b1;
                    ph = 4;
                end
            end
            default: begin
                if (servedIdx >= 0) pendArr[servedIdx] = 1'b0;
                if (timedOut) pendArr[2] = 1'b1;
                timedOut  = 1'b0;
                servedIdx = -1;
                ph = 0;
            end
        endcase
        if (acceptAll) begin
            for (int i = 0; i < 6; i++) if (req[i]) pendArr[i] = 1'b1;
        end
    endtask

    function automatic logic [5:0] expErr();
        logic [5:0] r;
        r = 6'b0;
        if (ph >= 1 && ph <= 3 && servedIdx >= 0) r[servedIdx] = 1'b1;
        return r;
    endfunction

    task automatic checkSig(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkSig({tag, ".build_enable"}, 32'(build_enable), 32'(ph == 1 || ph == 2));
        checkSig({tag, ".build_err"},    32'(build_err),    32'(expErr()));
        checkSig({tag, ".tx_valid"},     32'(tx_valid),     32'(ph == 3));
        checkSig({tag, ".tx_header"},    tx_header,         hdrQ);
        checkSig({tag, ".busy"},         32'(busy),         32'(ph != 0));
        checkSig({tag, ".timeout"},      32'(timeout),      32'(ph == 4 && timedOut));
        checkSig({tag, ".drop_count"},   32'(drop_count),   32'(dropCnt));
    endtask

    task automatic applyStimulus(input logic [5:0] req, input logic br, input logic [31:0] hdr,
                                 input logic tr, input string tag);
        @(negedge clk);
        err_req      = req;
        build_ready  = br;
        build_header = hdr;
        tx_ready     = tr;
        modelStep(req, br, hdr, tr);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] order[$];
        logic [5:0] expOrd[3];
        logic       prevEn;
        logic       seen;
        int         validCycles;
        int         startDrop;
        int         extra;
        int         anyValid;
        logic [5:0] busyErr;
        logic       found;

        err_req      = 6'b0;
        build_ready  = 1'b0;
        build_header = 32'b0;
        tx_ready     = 1'b0;
        reset_n      = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single Unsupported_Protocol request, builder ready one cycle after enable, tx always ready.
        vecs[0] = '{6'b000010, 1'b0, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b1};
        vecs[1] = '{6'b000000, 1'b0, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b1};
        vecs[2] = '{6'b000000, 1'b1, 1'b1, 1'b0, 6'b000010, 1'b1, 1'b1};
        vecs[3] = '{6'b000000, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1};
        vecs[4] = '{6'b000000, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].req, vecs[i].br, HDR, vecs[i].tr, "vec");
            checkSig("vec.tbl_enable", 32'(build_enable), 32'(vecs[i].expEn));
            checkSig("vec.tbl_err",    32'(build_err),    32'(vecs[i].expErr));
            checkSig("vec.tbl_valid",  32'(tx_valid),     32'(vecs[i].expValid));
            checkSig("vec.tbl_busy",   32'(busy),         32'(vecs[i].expBusy));
            if (i == 2) checkSig("vec.tbl_header", tx_header, HDR);
        end

        // Three simultaneous requests are served highest index first.
        expOrd[0] = 6'b100000;
        expOrd[1] = 6'b010000;
        expOrd[2] = 6'b000001;
        prevEn = build_enable;
        applyStimulus(6'b110001, 1'b0, HDR, 1'b1, "prio");
        if (build_enable && !prevEn) order.push_back(build_err);
        prevEn = build_enable;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(6'b0, 1'b1, $urandom, 1'b1, "prio");
            if (build_enable && !prevEn) order.push_back(build_err);
            prevEn = build_enable;
        end
        checkSig("prio.count", order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < order.size()) checkSig("prio.order", 32'(order[i]), 32'(expOrd[i]));
        end

        // Transmit never ready: abort after TMO cycles, then a Busy retry.
        applyStimulus(6'b000001, 1'b1, HDR, 1'b0, "tmo");
        validCycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(6'b0, 1'b1, $urandom, 1'b0, "tmo");
            if (tx_valid) validCycles++;
            if (timeout) seen = 1'b1;
        end
        checkSig("tmo.pulse_seen", 32'(seen), 32'd1);
        checkSig("tmo.valid_cycles", validCycles, TMO);
        busyErr = 6'b0;
        found = 1'b0;
        prevEn = build_enable;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(6'b0, 1'b1, $urandom, 1'b1, "tmo_retry");
            if (build_enable && !prevEn && !found) begin
                busyErr = build_err;
                found = 1'b1;
            end
            prevEn = build_enable;
            if (found && !busy) break;
        end
        checkSig("tmo.busy_err", 32'(busyErr), 32'(6'b000100));

        // Requests during SEND; handshake lands on the same cycle the limit is reached.
        startDrop = dropCnt;
        applyStimulus(6'b000100, 1'b1, HDR, 1'b0, "drop");
        applyStimulus(6'b000000, 1'b0, HDR, 1'b0, "drop");
        applyStimulus(6'b000000, 1'b1, 32'h1234_5678, 1'b0, "drop");
        for (int i = 0; i < 3; i++) applyStimulus(6'b000001, 1'b0, HDR, 1'b0, "drop");
        applyStimulus(6'b000000, 1'b0, HDR, 1'b1, "drop");
        checkSig("drop.no_timeout", 32'(timeout), 32'd0);
        checkSig("drop.count", 32'(drop_count), 32'(startDrop + (PEN == 1 ? 0 : 3)));
        extra = 0;
        prevEn = build_enable;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(6'b0, 1'b1, $urandom, 1'b1, "drop_after");
            if (build_enable && !prevEn) extra++;
            prevEn = build_enable;
        end
        checkSig("drop.extra_txn", extra, PEN);

        // Reset pulse while waiting for the builder.
        applyStimulus(6'b001000, 1'b0, HDR, 1'b0, "rst");
        applyStimulus(6'b000000, 1'b0, HDR, 1'b0, "rst");
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst.async");
        checkSig("rst.busy_low", 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        anyValid = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(6'b0, 1'b1, $urandom, 1'b1, "rst_after");
            if (tx_valid || build_enable) anyValid++;
        end
        checkSig("rst.no_tx", anyValid, 0);

        // Continuous request with tx stalled drives the drop counter into saturation.
        for (int i = 0; i < 320; i++) applyStimulus(6'b100000, 1'b1, $urandom, 1'b0, "sat");
        checkSig("sat.drop", 32'(drop_count), (PEN == 1) ? 32'd0 : 32'd255);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'b0,
                          1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 2) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
